count_monitor: RTL and testbench
================================

// Module: count_monitor
// PURPOSE
//  Receive-side checker for the free-running modulo counter bus (count 0..MODULUS-1, +1 per step,
//  wrap MODULUS-1 -> 0). Samples the bus on en, acquires lock after LOCK_CNT consecutive legal
//  steps, then flags and counts sequence errors and wraps. Sits on the consumer side of the counter.
// PARAMETERS
//  MODULUS   1000  counter modulus; legal values 0..MODULUS-1
//  CNT_W     10    width of count bus
//  LOCK_CNT  4     consecutive legal steps required to lock (>=1)
//  ERR_W     8     width of err_count (saturating)
//  WRAP_W    16    width of wrap_count (saturating)
// PORTS
//  clk         in   1       clock; all logic on posedge
//  rst         in   1       synchronous reset, active-high
//  en          in   1       count bus valid this cycle
//  count       in   CNT_W   sampled counter value
//  clr_stats   in   1       clear err_count and wrap_count
//  locked      out  1       monitor in LOCKED state
//  err_pulse   out  1       1-cycle pulse on sequence error while locked
//  wrap_pulse  out  1       1-cycle pulse on legal wrap while locked
//  err_count   out  ERR_W   errors seen while locked, saturating
//  wrap_count  out  WRAP_W  wraps seen while locked, saturating
// BEHAVIOUR
//  - Clock is clk; reset is synchronous and active-high on rst. rst has priority over all inputs.
//  - Reset: state=UNLOCKED, prev=0, good=0, locked=0, err_pulse=0, wrap_pulse=0,
//    err_count=0, wrap_count=0. Reset mid-stream discards lock; reacquire from scratch.
//  - All outputs registered; response appears the cycle after the sample (latency 1).
//  - en=0: nothing sampled; state, prev, good, counters held; pulses 0. Gaps are not errors.
//  - expected = (prev==MODULUS-1) ? 0 : prev+1. A sample matches iff count==expected and
//    count<MODULUS. Values >=MODULUS never match.
//  - prev <= count on every en=1 sample (including mismatches), any state.
//  - FSM (transitions only on en=1):
//    UNLOCKED: capture sample into prev, good=0 -> ACQUIRE (no check on first sample).
//    ACQUIRE: match -> good++; when good reaches LOCK_CNT -> LOCKED (locked=1 next cycle).
//             mismatch -> good=0, stay ACQUIRE; no err_pulse, no count.
//    LOCKED:  match -> stay; if prev==MODULUS-1 and count==0 -> wrap_pulse=1, wrap_count++.
//             mismatch -> err_pulse=1, err_count++, good=0 -> ACQUIRE, locked=0 next cycle.
//  - Wraps during ACQUIRE are not counted. Counters saturate at all-ones, never roll over.
//  - clr_stats: both counters -> 0 next cycle; wins over a simultaneous increment (result 0).
//    Does not affect state, locked or pulses.
//  - Width rule: expected computed in CNT_W bits; MODULUS-1 must fit CNT_W.
// TESTING
//  1 rst, then en=1 with count 0,1,2,3,4 on cycles 0..4 -> locked=1 from cycle 5; no pulses.
//  2 locked, feed 997,998,999,0,1 -> wrap_pulse=1 exactly one cycle after 0; wrap_count=1.
//  3 locked at 10,11 then 13 -> err_pulse one cycle after 13, err_count=1, locked=0;
//    then 14,15,16,17 -> locked=1 after 17; 13 not counted twice.
//  4 locked, feed 999 then 1000 -> err_pulse, err_count=1; out-of-range never matches.
//  5 locked at 20, en=0 for 3 cycles (bus garbage), en=1 with 21 -> no error, locked stays 1.
//  6 ERR_W=2: five lock/error cycles -> err_count saturates at 3; clr_stats same cycle as
//    wrap -> wrap_count=0 next cycle; rst mid-ACQUIRE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/count_monitor.sv
// Receive-side checker for a free-running modulo counter bus: locks after LOCK_CNT
// consecutive legal steps, then flags and counts sequence errors and legal wraps.
module count_monitor #(
  parameter int MODULUS  = 1000,
  parameter int CNT_W    = 10,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  count,
  input  logic              clr_stats,
  output logic              locked,
  output logic              err_pulse,
  output logic              wrap_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(MODULUS - 1);
  localparam logic [CNT_W:0]    MOD_X     = (CNT_W + 1)'(MODULUS);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + WRAP_W'(1);
  endfunction

  state_t             state_p1;
  logic [CNT_W-1:0]   prev_p1;
  logic [GOOD_W-1:0]  good_p1;

  logic               vld_p0;
  logic [CNT_W-1:0]   exp_p0;
  logic               match_p0;
  logic               wrap_p0;
  logic               err_evt_p0;
  logic               wrap_evt_p0;
  logic [GOOD_W-1:0]  good_nxt_p0;

  // Stage p0: compare the incoming sample against the successor of the last sample.
  always_comb begin
    vld_p0      = en;
    exp_p0      = (prev_p1 == LAST) ? '0 : prev_p1 + CNT_W'(1);
    match_p0    = (count == exp_p0) && ({1'b0, count} < MOD_X);
    wrap_p0     = match_p0 && (prev_p1 == LAST);
    err_evt_p0  = vld_p0 && (state_p1 == LOCKED) && !match_p0;
    wrap_evt_p0 = vld_p0 && (state_p1 == LOCKED) && wrap_p0;
    good_nxt_p0 = good_p1 + GOOD_W'(1);
  end

  // Stage p1: lock FSM, registered pulses and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1   <= UNLOCKED;
      prev_p1    <= '0;
      good_p1    <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err_pulse  <= err_evt_p0;
      wrap_pulse <= wrap_evt_p0;

      if (vld_p0) begin
        prev_p1 <= count;
        case (state_p1)
          UNLOCKED: begin
            good_p1  <= '0;
            state_p1 <= ACQUIRE;
          end
          ACQUIRE: begin
            if (match_p0) begin
              good_p1 <= good_nxt_p0;
              if (good_nxt_p0 == GOOD_LOCK) begin
                state_p1 <= LOCKED;
                locked   <= 1'b1;
              end
            end else begin
              good_p1 <= '0;
            end
          end
          LOCKED: begin
            if (!match_p0) begin
              good_p1  <= '0;
              state_p1 <= ACQUIRE;
              locked   <= 1'b0;
            end
          end
          default: begin
            good_p1  <= '0;
            state_p1 <= UNLOCKED;
            locked   <= 1'b0;
          end
        endcase
      end

      // A clear in the same cycle as an event wins and leaves the counter at zero.
      if (clr_stats) begin
        err_count  <= '0;
        wrap_count <= '0;
      end else begin
        if (err_evt_p0)  err_count  <= sat_inc_err(err_count);
        if (wrap_evt_p0) wrap_count <= sat_inc_wrap(wrap_count);
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: default instance plus an ERR_W=2 instance on the same bus.
module tb_count_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [9:0]  count = '0;
  logic        clr_stats = 1'b0;

  logic        a_locked, a_err_pulse, a_wrap_pulse;
  logic [7:0]  a_err_count;
  logic [15:0] a_wrap_count;
  logic        b_locked, b_err_pulse, b_wrap_pulse;
  logic [1:0]  b_err_count;
  logic [15:0] b_wrap_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  count_monitor dut_a (
    .clk(clk), .rst(rst), .en(en), .count(count), .clr_stats(clr_stats),
    .locked(a_locked), .err_pulse(a_err_pulse), .wrap_pulse(a_wrap_pulse),
    .err_count(a_err_count), .wrap_count(a_wrap_count)
  );

  count_monitor #(.ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .count(count), .clr_stats(clr_stats),
    .locked(b_locked), .err_pulse(b_err_pulse), .wrap_pulse(b_wrap_pulse),
    .err_count(b_err_count), .wrap_count(b_wrap_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; on return the registered response to it is visible.
  task automatic tick(input logic e, input int c, input logic clr);
    en        = e;
    count     = 10'(c);
    clr_stats = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic lk, input logic ep, input logic wp,
                       input int ec, input int wc);
    chk({tag, ".locked"}, 32'(a_locked), 32'(lk));
    chk({tag, ".err_pulse"}, 32'(a_err_pulse), 32'(ep));
    chk({tag, ".wrap_pulse"}, 32'(a_wrap_pulse), 32'(wp));
    chk({tag, ".err_count"}, 32'(a_err_count), 32'(ec));
    chk({tag, ".wrap_count"}, 32'(a_wrap_count), 32'(wc));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(1'b1, 7, 1'b0);
    tick(1'b0, 0, 1'b0);
    chk_a("reset", 1'b0, 1'b0, 1'b0, 0, 0);
    chk("reset.b_err_count", 32'(b_err_count), 32'd0);
    rst = 1'b0;

    // 1: lock after 0..4
    tick(1'b1, 0, 1'b0); chk_a("t1.s0", 1'b0, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 1, 1'b0); chk_a("t1.s1", 1'b0, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 2, 1'b0); chk_a("t1.s2", 1'b0, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 3, 1'b0); chk_a("t1.s3", 1'b0, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 4, 1'b0); chk_a("t1.s4", 1'b1, 1'b0, 1'b0, 0, 0);

    // 3: error at 13 while locked, then relock at 17
    for (int v = 5; v <= 11; v++) tick(1'b1, v, 1'b0);
    chk_a("t3.at11", 1'b1, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 13, 1'b0); chk_a("t3.s13", 1'b0, 1'b1, 1'b0, 1, 0);
    tick(1'b1, 14, 1'b0); chk_a("t3.s14", 1'b0, 1'b0, 1'b0, 1, 0);
    tick(1'b1, 15, 1'b0); chk_a("t3.s15", 1'b0, 1'b0, 1'b0, 1, 0);
    tick(1'b1, 16, 1'b0); chk_a("t3.s16", 1'b0, 1'b0, 1'b0, 1, 0);
    tick(1'b1, 17, 1'b0); chk_a("t3.s17", 1'b1, 1'b0, 1'b0, 1, 0);

    // 5: en=0 gap with garbage on the bus is not an error
    tick(1'b1, 18, 1'b0);
    tick(1'b1, 19, 1'b0);
    tick(1'b1, 20, 1'b0);
    tick(1'b0, 500, 1'b0); chk_a("t5.gap0", 1'b1, 1'b0, 1'b0, 1, 0);
    tick(1'b0, 0, 1'b0);   chk_a("t5.gap1", 1'b1, 1'b0, 1'b0, 1, 0);
    tick(1'b0, 1023, 1'b0); chk_a("t5.gap2", 1'b1, 1'b0, 1'b0, 1, 0);
    tick(1'b1, 21, 1'b0);  chk_a("t5.s21", 1'b1, 1'b0, 1'b0, 1, 0);

    // 4: 999 then out-of-range 1000
    rst = 1'b1; tick(1'b0, 0, 1'b0); rst = 1'b0;
    chk_a("t4.rst", 1'b0, 1'b0, 1'b0, 0, 0);
    for (int v = 995; v <= 999; v++) tick(1'b1, v, 1'b0);
    chk_a("t4.at999", 1'b1, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 1000, 1'b0); chk_a("t4.s1000", 1'b0, 1'b1, 1'b0, 1, 0);

    // Wrap during ACQUIRE is not counted
    rst = 1'b1; tick(1'b0, 0, 1'b0); rst = 1'b0;
    tick(1'b1, 997, 1'b0);
    tick(1'b1, 998, 1'b0);
    tick(1'b1, 999, 1'b0);
    tick(1'b1, 0, 1'b0); chk_a("acqwrap.s0", 1'b0, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 1, 1'b0); chk_a("acqwrap.s1", 1'b1, 1'b0, 1'b0, 0, 0);

    // 2: locked wrap 997,998,999,0,1
    rst = 1'b1; tick(1'b0, 0, 1'b0); rst = 1'b0;
    for (int v = 992; v <= 996; v++) tick(1'b1, v, 1'b0);
    tick(1'b1, 997, 1'b0); chk_a("t2.s997", 1'b1, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 998, 1'b0); chk_a("t2.s998", 1'b1, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 999, 1'b0); chk_a("t2.s999", 1'b1, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 0, 1'b0);   chk_a("t2.s0", 1'b1, 1'b0, 1'b1, 0, 1);
    tick(1'b1, 1, 1'b0);   chk_a("t2.s1", 1'b1, 1'b0, 1'b0, 0, 1);

    // 6: five lock/error rounds; ERR_W=2 saturates at 3
    rst = 1'b1; tick(1'b0, 0, 1'b0); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      int s;
      s = 100 + 11 * i;
      for (int v = s; v <= s + 4; v++) tick(1'b1, v, 1'b0);
      chk("t6.locked", 32'(a_locked), 32'd1);
      tick(1'b1, s + 10, 1'b0);
      chk("t6.a_err_count", 32'(a_err_count), 32'(i + 1));
      chk("t6.b_err_count", 32'(b_err_count), 32'((i + 1 > 3) ? 3 : i + 1));
      chk("t6.b_err_pulse", 32'(b_err_pulse), 32'd1);
    end

    // clr_stats in the same cycle as a locked wrap
    for (int v = 995; v <= 999; v++) tick(1'b1, v, 1'b0);
    tick(1'b1, 0, 1'b0); chk_a("t6.wrap1", 1'b1, 1'b0, 1'b1, 5, 1);
    for (int v = 1; v <= 999; v++) tick(1'b1, v, 1'b0);
    tick(1'b1, 0, 1'b1); chk_a("t6.clrwrap", 1'b1, 1'b0, 1'b1, 0, 0);
    chk("t6.clr.b_err_count", 32'(b_err_count), 32'd0);

    // rst mid-ACQUIRE clears everything, then reacquire from scratch
    tick(1'b1, 50, 1'b0); chk_a("t6.err50", 1'b0, 1'b1, 1'b0, 1, 0);
    tick(1'b1, 51, 1'b0);
    rst = 1'b1; tick(1'b1, 52, 1'b0); rst = 1'b0;
    chk_a("t6.rstacq", 1'b0, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 52, 1'b0);
    tick(1'b1, 53, 1'b0);
    tick(1'b1, 54, 1'b0);
    tick(1'b1, 55, 1'b0); chk_a("t6.reacq55", 1'b0, 1'b0, 1'b0, 0, 0);
    tick(1'b1, 56, 1'b0); chk_a("t6.reacq56", 1'b1, 1'b0, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
